// File: rtl/ram_loader_pkg.sv
// ram_loader shared types: FSM states and error codes.
// Imported by the loader top.
package ram_loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HDR_ADDR,
    HDR_CNT,
    FETCH,
    WRITE,
    WAIT_RESP,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam int ERR_W = 2;

  typedef enum logic [ERR_W-1:0] {
    ERR_NONE  = 2'd0,
    ERR_ADDR  = 2'd1,
    ERR_LEN   = 2'd2,
    ERR_CKSUM = 2'd3
  } err_t;

  function automatic logic is_rd_state(input state_t s);
    return s inside {IDLE, HDR_ADDR, HDR_CNT, FETCH, CHECK};
  endfunction

endpackage

// File: rtl/ram_loader_cksum.sv
// Running modulo-2^DATA_W sum of the image data words.
// Clear has priority over add.
module ram_loader_cksum #(
  parameter int DATA_W = 32
) (
  input  logic              clk_sys_i,
  input  logic              rst_sys_ni,
  input  logic              clear,
  input  logic              add_en,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] sum
);

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + data;
    end
  end

endmodule

// File: rtl/ram_loader.sv
// Boot image loader: streams a header + data image from an RX FIFO
// into memory, verifies the checksum and releases the core reset.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 16384,
  parameter bit CKSUM_EN  = 1'b1
) (
  input  logic                clk_sys_i,
  input  logic                rst_sys_ni,
  input  logic                restart_i,
  input  logic                fifo_empty_i,
  output logic                fifo_rd_o,
  input  logic                fifo_rvalid_i,
  input  logic [DATA_W-1:0]   fifo_data_i,
  output logic                mem_req_o,
  input  logic                mem_gnt_i,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic                mem_rvalid_i,
  output logic                core_rst_no,
  output logic                done_o,
  output logic                err_o,
  output logic [1:0]          err_code_o,
  output logic [ADDR_W-1:0]   words_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int CW    = $clog2(MAX_WORDS + 1);
  localparam int EW    = ADDR_W + DATA_W + 1;

  state_t          state;
  logic            rd_pend;
  logic [CW-1:0]   left_q;
  logic [DATA_W-1:0] sum;

  logic            rd_ok;
  logic            take;
  logic            ck_add;
  logic            len_bad;
  logic            span_bad;
  logic            mis_al;
  logic [EW-1:0]   end_addr;

  // One read in flight at most; the reply clears the pending flag.
  assign rd_ok = is_rd_state(state) & ~fifo_empty_i & ~rd_pend;
  assign take  = rd_pend & fifo_rvalid_i;

  assign ck_add = (state == FETCH) & take;

  assign mis_al  = fifo_data_i[BSH-1:0] != '0;
  assign len_bad = fifo_data_i > DATA_W'(MAX_WORDS);

  // Wide enough that base + N*BYTES never wraps.
  assign end_addr = EW'(mem_addr_o)
                  + (EW'(fifo_data_i) << BSH);
  assign span_bad = end_addr > (EW'(1) << ADDR_W);

  ram_loader_cksum #(
    .DATA_W (DATA_W)
  ) u_cksum (
    .clk_sys_i  (clk_sys_i),
    .rst_sys_ni (rst_sys_ni),
    .clear      (restart_i),
    .add_en     (ck_add),
    .data       (fifo_data_i),
    .sum        (sum)
  );

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state       <= IDLE;
      rd_pend     <= 1'b0;
      left_q      <= '0;
      fifo_rd_o   <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
      core_rst_no <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      err_code_o  <= ERR_NONE;
      words_o     <= '0;
    end else if (restart_i) begin
      state       <= IDLE;
      rd_pend     <= 1'b0;
      left_q      <= '0;
      fifo_rd_o   <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      core_rst_no <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      err_code_o  <= ERR_NONE;
      words_o     <= '0;
    end else begin
      fifo_rd_o <= rd_ok;
      if (rd_ok) begin
        rd_pend <= 1'b1;
      end else if (take) begin
        rd_pend <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (rd_ok) state <= HDR_ADDR;
        end

        HDR_ADDR: begin
          if (take) begin
            mem_addr_o <= ADDR_W'(fifo_data_i);
            if (mis_al) begin
              state      <= ERROR;
              err_o      <= 1'b1;
              err_code_o <= ERR_ADDR;
            end else begin
              state <= HDR_CNT;
            end
          end
        end

        HDR_CNT: begin
          if (take) begin
            if (len_bad) begin
              state      <= ERROR;
              err_o      <= 1'b1;
              err_code_o <= ERR_LEN;
            end else if (span_bad) begin
              state      <= ERROR;
              err_o      <= 1'b1;
              err_code_o <= ERR_ADDR;
            end else if (fifo_data_i == '0) begin
              if (CKSUM_EN) begin
                state <= CHECK;
              end else begin
                state       <= DONE;
                done_o      <= 1'b1;
                core_rst_no <= 1'b1;
              end
            end else begin
              left_q <= CW'(fifo_data_i);
              state  <= FETCH;
            end
          end
        end

        FETCH: begin
          if (take) begin
            mem_wdata_o <= fifo_data_i;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b1;
            mem_be_o    <= '1;
            state       <= WRITE;
          end
        end

        WRITE: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            mem_be_o  <= '0;
            state     <= WAIT_RESP;
          end
        end

        WAIT_RESP: begin
          if (mem_rvalid_i) begin
            mem_addr_o <= mem_addr_o + ADDR_W'(BYTES);
            words_o    <= words_o + ADDR_W'(1);
            left_q     <= left_q - CW'(1);
            if (left_q != CW'(1)) begin
              state <= FETCH;
            end else if (CKSUM_EN) begin
              state <= CHECK;
            end else begin
              state       <= DONE;
              done_o      <= 1'b1;
              core_rst_no <= 1'b1;
            end
          end
        end

        CHECK: begin
          if (take) begin
            if (fifo_data_i == sum) begin
              state       <= DONE;
              done_o      <= 1'b1;
              core_rst_no <= 1'b1;
            end else begin
              state      <= ERROR;
              err_o      <= 1'b1;
              err_code_o <= ERR_CKSUM;
            end
          end
        end

        DONE: begin
          state <= DONE;
        end

        ERROR: begin
          state <= ERROR;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: FIFO and memory responders, directed table
// of images, restart sequence and randomized images vs. a model.
module tb_ram_loader;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        restart = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd;
  logic        fifo_rvalid = 1'b0;
  logic [31:0] fifo_data = '0;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid = 1'b0;
  logic        core_rst_n;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [31:0] words;

  always #5 clk = ~clk;

  ram_loader #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MAX_WORDS (MW),
    .CKSUM_EN  (1'b1)
  ) dut (
    .clk_sys_i     (clk),
    .rst_sys_ni    (rst_n),
    .restart_i     (restart),
    .fifo_empty_i  (fifo_empty),
    .fifo_rd_o     (fifo_rd),
    .fifo_rvalid_i (fifo_rvalid),
    .fifo_data_i   (fifo_data),
    .mem_req_o     (mem_req),
    .mem_gnt_i     (mem_gnt),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_be_o      (mem_be),
    .mem_rvalid_i  (mem_rvalid),
    .core_rst_no   (core_rst_n),
    .done_o        (done),
    .err_o         (err),
    .err_code_o    (err_code),
    .words_o       (words)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Environment state
  logic [31:0] fq[$];
  logic [31:0] img[$];
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic        rd_seen = 1'b0;
  bit          gaps = 1'b0;
  int          gnt_dly = 0;
  int          rsp_dly = 0;
  int          gnt_cnt = 0;
  int          rsp_cnt = 0;
  int          rd_cnt = 0;
  bit          req_act = 1'b0;
  bit          held = 1'b1;
  logic [31:0] cap_a = '0;
  logic [31:0] cap_d = '0;

  // FIFO answers a read one cycle later; memory grants after gnt_dly
  always @(negedge clk) begin
    fifo_rvalid = 1'b0;
    if (rd_seen) begin
      fifo_rvalid = 1'b1;
      fifo_data = (fq.size() != 0) ? fq.pop_front() : 32'hdead_beef;
    end
    rd_seen = fifo_rd;
    if (fifo_rd) rd_cnt++;
    fifo_empty = (fq.size() == 0) ||
                 (gaps && $urandom_range(0, 2) == 0);

    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) mem_rvalid = 1'b1;
    end
    if (mem_req) begin
      if (!req_act) begin
        req_act = 1'b1;
        cap_a = mem_addr;
        cap_d = mem_wdata;
        gnt_cnt = gnt_dly;
        held = 1'b1;
      end else if (mem_addr !== cap_a || mem_wdata !== cap_d) begin
        held = 1'b0;
      end
      if (gnt_cnt == 0) begin
        mem_gnt = 1'b1;
        req_act = 1'b0;
        wa.push_back(mem_addr);
        wd.push_back(mem_wdata);
        chk("req_hold", 64'(held), 64'd1);
        chk("we_be", {mem_we, mem_be}, 64'h1f);
        rsp_cnt = rsp_dly + 1;
      end else begin
        gnt_cnt--;
      end
    end
  end

  typedef struct {
    bit         done;
    bit         err;
    logic [1:0] code;
    int         words;
    int         nw;
  } exp_t;

  typedef struct {
    logic [31:0] base;
    int          n;
    logic [31:0] d0;
    logic [31:0] ckoff;
    int          gd;
    int          rd;
    bit          gp;
    bit          x_done;
    bit          x_err;
    logic [1:0]  x_code;
    int          x_words;
  } vec_t;

  // Outcome of a load computed straight from the image rules
  function automatic exp_t model(input logic [31:0] base,
                                 input int n,
                                 input logic [31:0] ck);
    exp_t e;
    logic [63:0] lim;
    logic [31:0] s;
    e = '{default: 0};
    s = '0;
    lim = {32'd0, base} + 64'(n) * 64'd4;
    if (base % 4 != 0) begin
      e.err = 1'b1; e.code = 2'd1;
    end else if (n > MW) begin
      e.err = 1'b1; e.code = 2'd2;
    end else if (lim > 64'h1_0000_0000) begin
      e.err = 1'b1; e.code = 2'd1;
    end else begin
      foreach (img[i]) s += img[i];
      e.words = n;
      e.nw = n;
      if (s == ck) e.done = 1'b1;
      else begin e.err = 1'b1; e.code = 2'd3; end
    end
    return e;
  endfunction

  task automatic flush_restart();
    @(posedge clk); #1;
    fq.delete();
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic fill(input logic [31:0] base,
                      input logic [31:0] n,
                      input logic [31:0] ck);
    @(posedge clk); #1;
    wa.delete();
    wd.delete();
    fq.push_back(base);
    fq.push_back(n);
    foreach (img[i]) fq.push_back(img[i]);
    fq.push_back(ck);
  endtask

  task automatic wait_end(input string tag);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done || err) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s.timeout: got no done/err want done/err", tag);
    end
  endtask

  task automatic check_res(input string tag,
                           input exp_t e,
                           input logic [31:0] base);
    int rc;
    repeat (3) @(negedge clk);
    chk({tag, ".done"}, 64'(done), 64'(e.done));
    chk({tag, ".err"}, 64'(err), 64'(e.err));
    chk({tag, ".code"}, 64'(err_code), 64'(e.code));
    chk({tag, ".words"}, 64'(words), 64'(e.words));
    chk({tag, ".core_rst"}, 64'(core_rst_n), 64'(e.done));
    chk({tag, ".nwr"}, 64'(wa.size()), 64'(e.nw));
    for (int i = 0; i < wa.size() && i < e.nw; i++) begin
      chk({tag, ".addr"}, 64'(wa[i]), 64'(base + 32'(i * 4)));
      chk({tag, ".data"}, 64'(wd[i]), 64'(img[i]));
    end
    // Terminal states must leave the FIFO and memory alone
    rc = rd_cnt;
    @(posedge clk); #1;
    fq.push_back(32'h1234_5678);
    fq.push_back(32'h9abc_def0);
    repeat (8) @(negedge clk);
    chk({tag, ".idle_rd"}, 64'(rd_cnt - rc), 64'd0);
    chk({tag, ".idle_wr"}, 64'(wa.size()), 64'(e.nw));
  endtask

  task automatic run_img(input string tag,
                         input logic [31:0] base,
                         input int n,
                         input logic [31:0] ck,
                         input exp_t e);
    flush_restart();
    fill(base, 32'(n), ck);
    wait_end(tag);
    check_res(tag, e, base);
  endtask

  vec_t        tbl[10];
  exp_t        e;
  logic [31:0] s;
  logic [31:0] base;
  int          n;
  int          r;

  initial begin
    tbl[0] = '{32'h0010_0000, 3, 1, 0, 0, 0, 0, 1, 0, 2'd0, 3};
    tbl[1] = '{32'h0010_0000, 3, 1, 1, 0, 0, 0, 0, 1, 2'd3, 3};
    tbl[2] = '{32'h0010_0002, 3, 1, 0, 0, 0, 0, 0, 1, 2'd1, 0};
    tbl[3] = '{32'h0010_0000, 17, 1, 0, 0, 0, 0, 0, 1, 2'd2, 0};
    tbl[4] = '{32'h0010_0000, 0, 1, 0, 0, 0, 0, 1, 0, 2'd0, 0};
    tbl[5] = '{32'hFFFF_FFF8, 2, 5, 0, 1, 1, 0, 1, 0, 2'd0, 2};
    tbl[6] = '{32'hFFFF_FFF8, 3, 5, 0, 0, 0, 0, 0, 1, 2'd1, 0};
    tbl[7] = '{32'h0000_0100, 16, 32'hFFFF_FFF0, 0, 0, 0, 1,
               1, 0, 2'd0, 16};
    tbl[8] = '{32'h0000_2000, 4, 10, 0, 5, 2, 1, 1, 0, 2'd0, 4};
    tbl[9] = '{32'h0000_0040, 1, 7, 32'hFFFF_FFFF, 0, 0, 0,
               0, 1, 2'd3, 1};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctl",
        {fifo_rd, mem_req, mem_we, core_rst_n, done, err, err_code},
        64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_be", 64'(mem_be), 64'd0);
    chk("rst_words", 64'(words), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed table
    for (int k = 0; k < 10; k++) begin
      gnt_dly = tbl[k].gd;
      rsp_dly = tbl[k].rd;
      gaps = tbl[k].gp;
      img.delete();
      s = '0;
      for (int i = 0; i < tbl[k].n && i < MW; i++) begin
        img.push_back(tbl[k].d0 + 32'(i));
        s += tbl[k].d0 + 32'(i);
      end
      e.done = tbl[k].x_done;
      e.err = tbl[k].x_err;
      e.code = tbl[k].x_code;
      e.words = tbl[k].x_words;
      e.nw = tbl[k].x_words;
      run_img($sformatf("vec%0d", k), tbl[k].base, tbl[k].n,
              s + tbl[k].ckoff, e);
    end

    // Restart in the response wait of the second word, then reload
    gnt_dly = 0;
    rsp_dly = 3;
    gaps = 1'b0;
    img.delete();
    img.push_back(32'd1);
    img.push_back(32'd2);
    img.push_back(32'd3);
    flush_restart();
    fill(32'h0010_0000, 32'd3, 32'd6);
    r = 0;
    while (!(wa.size() == 2 && !mem_req) && r < 500) begin
      @(negedge clk);
      r++;
    end
    if (r >= 500) begin
      total++;
      bad++;
      $display("FAIL rst.timeout: got %0d writes want 2", wa.size());
    end
    chk("rst.words_pre", 64'(words), 64'd1);
    restart = 1'b1;
    @(posedge clk); #1;
    fq.delete();
    chk("rst.core_rst", 64'(core_rst_n), 64'd0);
    chk("rst.words", 64'(words), 64'd0);
    chk("rst.flags", {done, err, err_code}, 64'd0);
    @(negedge clk); restart = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst.no_req", 64'(mem_req), 64'd0);
    fill(32'h0010_0000, 32'd3, 32'd6);
    wait_end("reload");
    e = '{done: 1'b1, err: 1'b0, code: 2'd0, words: 3, nw: 3};
    check_res("reload", e, 32'h0010_0000);

    // Randomized images against the model
    for (int k = 0; k < 24; k++) begin
      n = $urandom_range(0, MW + 1);
      r = $urandom_range(0, 9);
      if (r == 0) base = $urandom() | 32'd1;
      else if (r < 3)
        base = 32'hFFFF_FF00 + 32'($urandom_range(0, 63) * 4);
      else base = $urandom() & 32'h00FF_FFFC;
      img.delete();
      s = '0;
      for (int i = 0; i < n && i < MW; i++) begin
        img.push_back($urandom());
        s += img[i];
      end
      if ($urandom_range(0, 3) == 0) s += 32'($urandom_range(1, 9));
      gnt_dly = $urandom_range(0, 3);
      rsp_dly = $urandom_range(0, 2);
      gaps = 1'($urandom_range(0, 1));
      e = model(base, n, s);
      run_img($sformatf("rnd%0d", k), base, n, s, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width in bits.
REQ-002 Parameter DATA_W, default 32, word width in bits (32 or 64).
REQ-003 Parameter MAX_WORDS, default 16384, largest accepted image length in words.
REQ-004 Parameter CKSUM_EN, default 1, enables the trailing checksum word.
REQ-005 The block SHALL have these ports (name direction width meaning):
- clk_sys_i  in  1  system clock
- rst_sys_ni  in  1  reset, asynchronous, active-low
- restart_i  in  1  single-cycle pulse; abort and reload
- fifo_empty_i  in  1  RX FIFO empty
- fifo_rd_o  out  1  RX FIFO read strobe, one cycle
- fifo_rvalid_i  in  1  fifo_data_i valid
- fifo_data_i  in  DATA_W  RX word
- mem_req_o  out  1  memory request
- mem_gnt_i  in  1  memory grant
- mem_we_o  out  1  write enable, always 1 with req
- mem_addr_o  out  ADDR_W  byte address
- mem_wdata_o  out  DATA_W  write data
- mem_be_o  out  DATA_W/8  byte enables, all ones
- mem_rvalid_i  in  1  write response
- core_rst_no  out  1  core reset, low until a good load completes
- done_o  out  1  load completed and checksum passed
- err_o  out  1  load failed
- err_code_o  out  2  0 none, 1 misaligned/overflow, 2 length, 3 checksum
- words_o  out  ADDR_W  data words written so far

Function
REQ-010 Image format SHALL be word0 = base byte address, word1 = word count N, then N data words, then one checksum word if CKSUM_EN.
REQ-011 States SHALL be IDLE, HDR_ADDR, HDR_CNT, FETCH, WRITE, WAIT_RESP, CHECK, DONE, ERROR.
REQ-012 In IDLE, HDR_ADDR, HDR_CNT, FETCH and CHECK with fifo_empty_i=0 and no read outstanding, the block SHALL pulse fifo_rd_o for one cycle and then wait for fifo_rvalid_i, with at most one read outstanding.
REQ-013 IDLE SHALL go to HDR_ADDR on the first read issue; HDR_ADDR SHALL latch the address on rvalid and go to HDR_CNT.
REQ-014 The base address SHALL be checked on latch: low log2(DATA_W/8) bits nonzero -> ERROR, code 1.
REQ-015 HDR_CNT SHALL latch N on rvalid; N > MAX_WORDS -> ERROR, code 2; base + N*(DATA_W/8) beyond 2^ADDR_W -> ERROR, code 1; N=0 -> CHECK, or DONE if CKSUM_EN=0; otherwise -> FETCH.
REQ-016 FETCH SHALL register the data word on rvalid, add it into the checksum (sum modulo 2^DATA_W), and go to WRITE.
REQ-017 WRITE SHALL hold mem_req_o, mem_addr_o and mem_wdata_o stable until the cycle mem_gnt_i=1, then deassert req next cycle and go to WAIT_RESP.
REQ-018 WAIT_RESP on mem_rvalid_i SHALL advance the address by DATA_W/8 and increment words_o, then go to FETCH, or to CHECK/DONE after word N.
REQ-019 CHECK SHALL compare the received word to the accumulated sum: equal -> DONE, unequal -> ERROR, code 3.
REQ-020 DONE SHALL drive done_o=1 and core_rst_no=1 from the cycle after entry, and SHALL ignore further FIFO data (fifo_rd_o=0).
REQ-021 ERROR SHALL hold err_o=1, err_code_o and core_rst_no=0, and SHALL issue no FIFO reads and no memory requests.
REQ-022 restart_i SHALL, from any state, drive core_rst_no=0 and clear done_o, err_o, err_code_o, words_o and the checksum on the next cycle, then go to IDLE.
REQ-023 A pending grant or response coinciding with restart_i SHALL be discarded; restart_i has priority over every other transition.
REQ-024 Outputs SHALL be registered; the latency from fifo_rvalid_i to mem_req_o is 1 cycle.

Reset
REQ-030 On rst_sys_ni=0: state IDLE, fifo_rd_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, mem_be_o=0, core_rst_no=0, done_o=0, err_o=0, err_code_o=0, words_o=0, checksum 0.
REQ-031 No delayed or non-blocking-mixed assignments; all flops reset asynchronously.

Structure
REQ-040 Package ram_loader_pkg SHALL hold the state enum, the error-code enum and its constants.
REQ-041 Sub-module ram_loader_cksum (clear, add-enable, data, sum) SHALL hold the checksum accumulator.

Verification
REQ-050 Base 0x0010_0000, N=3, data 1,2,3, cksum 6 -> writes at 0x0010_0000/04/08, done_o=1, core_rst_no=1, words_o=3.
REQ-051 Same image, cksum 7 -> three writes, err_o=1, code 3, core_rst_no=0.
REQ-052 Base 0x0010_0002 -> no writes, err_o=1, code 1; N=MAX_WORDS+1 -> code 2.
REQ-053 N=0, cksum 0 -> no memory requests, done_o=1.
REQ-054 mem_gnt_i delayed 5 cycles and FIFO empty gaps -> req/addr/data held stable, image correct.
REQ-055 restart_i during WAIT_RESP of word 2 -> core_rst_no=0, words_o=0, then a full reload succeeds.
